tte_frame_enqueue: RTL and testbench
====================================

Name: tte_frame_enqueue

Overview:
- Downstream stage of the TT-frame lookup/forwarding block; consumes its sof/dv/data byte stream.
- Stream format: byte 0 = {len[11:8], portmap[3:0]}, byte 1 = len[7:0], then frame bytes, then optional pad bytes while dv stays high.
- Stores the first L frame bytes into a shared byte buffer and emits one descriptor per accepted frame through a valid/ready queue.
- Tracks buffer free space, drives backpressure bp0..bp3 to the upstream stage, and drops or aborts bad frames without leaking buffer space.

Parameters:
- DBUF_AW, 12, byte-buffer address width (buffer depth 2^DBUF_AW bytes).
- MAX_FRAME, 1536, largest legal L; also the backpressure free-space threshold.
- MIN_FRAME, 60, smallest legal L.
- DESC_DEPTH, 8, internal descriptor FIFO depth (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sof  in  1  first byte of stream frame (coincident with dv).
- dv  in  1  stream byte valid.
- data  in  8  stream byte.
- bp0, bp1, bp2, bp3  out  1 each  backpressure to upstream; all four carry the same value.
- dbuf_wr  out  1  buffer write strobe.
- dbuf_waddr  out  DBUF_AW  buffer write address.
- dbuf_din  out  8  buffer write data.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  consumer accepts descriptor.
- desc_data  out  16+DBUF_AW  {portmap[3:0], len[11:0], start_addr[DBUF_AW-1:0]}.
- rel  in  1  consumer frees rel_len bytes.
- rel_len  in  12  byte count released.
- drop_cnt  out  16  frames dropped at admission.
- err_cnt  out  16  frames aborted (malformed or truncated).

Behaviour:
- Reset (async, rst=1): all outputs 0, bp* = 0, free = 2^DBUF_AW, wr_ptr = 0, counters 0, descriptor FIFO empty, state IDLE.
- A reset mid-frame discards the partial frame entirely.
- FSM states: IDLE, HDR1, BODY, DRAIN, COMMIT, ABORT.
- IDLE:
  - On sof&dv, latch portmap and len_hi, record start = wr_ptr, go to HDR1.
  - dv without sof is ignored.
- HDR1:
  - On dv, form L = {len_hi, data}.
  - Admission check; drop if any of: portmap == 0, free < L, or descriptor FIFO full. A drop increments drop_cnt (saturating) and goes to DRAIN.
  - Error if L < MIN_FRAME or L > MAX_FRAME: increments err_cnt and goes to DRAIN.
  - Otherwise go to BODY with remaining = L.
  - If dv falls here, go to ABORT.
- BODY:
  - Each dv byte drives dbuf_wr=1, dbuf_waddr=wr_ptr, dbuf_din=data, then wr_ptr++ (wraps modulo 2^DBUF_AW) and remaining--.
  - Writes are combinational from the registered stream, i.e. the same cycle the byte is sampled.
  - When remaining reaches 0, go to DRAIN_OK, a sub-flag of DRAIN.
  - dv falling with remaining > 0 goes to ABORT.
  - sof during BODY goes to ABORT, and that sof is re-evaluated as a new frame start the next cycle.
- DRAIN: discard bytes while dv=1. When dv=0, go to COMMIT if the accepted flag is set, else IDLE.
- COMMIT (one cycle):
  - Push {portmap, L, start} into the descriptor FIFO.
  - free -= L.
  - Return to IDLE.
  - desc_valid rises the following cycle.
- ABORT (one cycle): wr_ptr <= start, err_cnt++ (saturating), back to IDLE. No descriptor is produced and free is unchanged.
- Free accounting:
  - free is reduced only at COMMIT, so aborted bytes are simply overwritten later.
  - rel adds rel_len to free in the same cycle.
  - COMMIT and rel in the same cycle: free <= free - L + rel_len.
  - free never exceeds 2^DBUF_AW; an overflow is clamped and err_cnt is incremented.
- Backpressure: bp* = registered (free < MAX_FRAME) OR (desc FIFO count >= DESC_DEPTH-1).
  - bp is advisory, sampled by upstream between frames only.
  - Admission checks still guard correctness.
- Descriptor FIFO:
  - First-word-fall-through.
  - desc_data is held stable while desc_valid=1 and desc_ready=0.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: last stored byte to desc_valid = at least 2 cycles (DRAIN until dv low, then COMMIT, then FIFO output).

Decomposition:
- Shared package tte_pkg holds:
  - state encoding;
  - descriptor field offsets (PM_HI/LO, LEN_HI/LO, ADDR_HI/LO);
  - MIN_FRAME/MAX_FRAME defaults.
- One sub-module: tte_desc_fifo, a synchronous FWFT FIFO parameterised by width/depth, with count output.

Test Plan:
- Legal frame: portmap=4'b0101, L=64, 64 bytes + 4 pad bytes, dv high throughout -> 64 writes at addresses 0..63, pad not written, desc_data={5, 64, 0}, free=4096-64.
- portmap=0, L=100 -> no writes, drop_cnt=1, no descriptor, wr_ptr unchanged.
- Truncation: L=200 but dv drops after 120 bytes -> err_cnt=1, wr_ptr returns to start; next legal frame is written from the same start address.
- Fill: send 2 frames of L=1536 without rel -> free=1024, bp*=1; third frame L=1536 -> drop_cnt=1; then rel with rel_len=1536 -> bp*=0 next cycle.
- Wrap: wr_ptr=4090, L=64 -> addresses 4090..4095 then 0..57, descriptor start=4090.
- Simultaneous events: COMMIT (L=64) in the same cycle as rel with rel_len=100 -> free increases by 36. desc_ready=0 for 8 frames -> FIFO full, following frame dropped; desc_data held stable.

Source files
------------

// File: rtl/tte_pkg.sv
// Shared types and constants for the TT-frame enqueue stage: FSM encoding,
// descriptor field layout and frame-length limits.
package tte_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr1,
    StBody,
    StDrain,
    StCommit,
    StAbort
  } state_e;

  localparam int unsigned MIN_FRAME_DEF = 60;
  localparam int unsigned MAX_FRAME_DEF = 1536;
  localparam int unsigned DBUF_AW_DEF   = 12;
  localparam int unsigned LEN_W         = 12;
  localparam int unsigned PM_W          = 4;

  // Descriptor layout {portmap, len, start_addr} for the default buffer width.
  localparam int unsigned ADDR_LO = 0;
  localparam int unsigned ADDR_HI = DBUF_AW_DEF - 1;
  localparam int unsigned LEN_LO  = DBUF_AW_DEF;
  localparam int unsigned LEN_HI  = LEN_LO + LEN_W - 1;
  localparam int unsigned PM_LO   = LEN_HI + 1;
  localparam int unsigned PM_HI   = PM_LO + PM_W - 1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hffff : s[15:0];
  endfunction

endpackage

// File: rtl/tte_desc_fifo.sv
// First-word-fall-through descriptor FIFO with occupancy count.
module tte_desc_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && (cnt_q != CntW'(Depth));
    do_pop   = pop_i && (cnt_q != '0);
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  // Gate the head entry so the output reads zero while empty.
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/tte_frame_enqueue.sv
// Frame enqueue stage: stores admitted frames into the byte buffer, tracks free
// space, and queues one {portmap, len, start} descriptor per committed frame.
module tte_frame_enqueue
  import tte_pkg::*;
#(
  parameter int unsigned DBUF_AW    = 12,
  parameter int unsigned MAX_FRAME  = MAX_FRAME_DEF,
  parameter int unsigned MIN_FRAME  = MIN_FRAME_DEF,
  parameter int unsigned DESC_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  dv,
  input  logic [7:0]            data,
  output logic                  bp0,
  output logic                  bp1,
  output logic                  bp2,
  output logic                  bp3,
  output logic                  dbuf_wr,
  output logic [DBUF_AW-1:0]    dbuf_waddr,
  output logic [7:0]            dbuf_din,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [16+DBUF_AW-1:0] desc_data,
  input  logic                  rel,
  input  logic [11:0]           rel_len,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           err_cnt
);

  localparam int unsigned DescW    = 16 + DBUF_AW;
  localparam int unsigned CntW     = $clog2(DESC_DEPTH + 1);
  localparam int unsigned FreeW    = DBUF_AW + 1;
  localparam int unsigned BufBytes = 32'd1 << DBUF_AW;

  state_e               state_q, state_d;
  logic                 s_sof_q, s_sof_d, s_dv_q, s_dv_d;
  logic [7:0]           s_data_q, s_data_d;
  logic [3:0]           pm_q, pm_d, len_hi_q, len_hi_d;
  logic [11:0]          len_q, len_d, rem_q, rem_d;
  logic [DBUF_AW-1:0]   wr_ptr_q, wr_ptr_d, start_q, start_d;
  logic                 acc_q, acc_d, pend_q, pend_d;
  logic [FreeW-1:0]     free_q, free_d;
  logic                 bp_q, bp_d;
  logic [15:0]          drop_q, drop_d, err_q, err_d;

  logic [11:0]          hdr_len;
  logic                 hdr_drop, hdr_bad, do_hdr, wr_en, commit;
  logic                 drop_inc;
  logic [1:0]           err_inc;
  logic [31:0]          free_sum;
  logic                 fifo_full;
  logic [CntW-1:0]      fifo_cnt;

  tte_desc_fifo #(
    .Width (DescW),
    .Depth (DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (commit),
    .wdata_i ({pm_q, len_q, start_q}),
    .full_o  (fifo_full),
    .pop_i   (desc_ready),
    .valid_o (desc_valid),
    .rdata_o (desc_data),
    .count_o (fifo_cnt)
  );

  always_comb begin
    s_sof_d  = sof;
    s_dv_d   = dv;
    s_data_d = data;
    state_d  = state_q;
    pm_d     = pm_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    start_d  = start_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    drop_inc = 1'b0;
    err_inc  = 2'd0;
    do_hdr   = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;

    hdr_len  = {len_hi_q, s_data_q};
    hdr_drop = (pm_q == 4'd0) || (32'(free_q) < 32'(hdr_len)) || fifo_full;
    hdr_bad  = (32'(hdr_len) < MIN_FRAME) || (32'(hdr_len) > MAX_FRAME);

    unique case (state_q)
      StIdle: begin
        if (s_sof_q && s_dv_q) begin
          pm_d     = s_data_q[3:0];
          len_hi_d = s_data_q[7:4];
          start_d  = wr_ptr_q;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (s_dv_q) do_hdr = 1'b1;
        else        state_d = StAbort;
      end
      StBody: begin
        if (!s_dv_q) begin
          state_d = StAbort;
        end else if (s_sof_q) begin
          // Hold the new header; the abort cycle then handles its length byte.
          state_d  = StAbort;
          pend_d   = 1'b1;
          pm_d     = s_data_q[3:0];
          len_hi_d = s_data_q[7:4];
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rem_d    = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            acc_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!s_dv_q) state_d = acc_q ? StCommit : StIdle;
      end
      StCommit: begin
        commit  = 1'b1;
        acc_d   = 1'b0;
        state_d = StIdle;
      end
      StAbort: begin
        wr_ptr_d = start_q;
        err_inc  = 2'd1;
        pend_d   = 1'b0;
        state_d  = StIdle;
        if (pend_q) begin
          if (s_dv_q) do_hdr = 1'b1;
          else        state_d = StAbort;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_hdr) begin
      len_d = hdr_len;
      acc_d = 1'b0;
      if (hdr_drop) begin
        drop_inc = 1'b1;
        state_d  = StDrain;
      end else if (hdr_bad) begin
        err_inc = err_inc + 2'd1;
        state_d = StDrain;
      end else begin
        rem_d   = hdr_len;
        state_d = StBody;
      end
    end

    free_sum = 32'(free_q) - (commit ? 32'(len_q) : 32'd0) + (rel ? 32'(rel_len) : 32'd0);
    if (free_sum > BufBytes) begin
      free_d  = FreeW'(BufBytes);
      err_inc = err_inc + 2'd1;
    end else begin
      free_d = FreeW'(free_sum);
    end

    bp_d   = (32'(free_d) < MAX_FRAME) || (32'(fifo_cnt) >= DESC_DEPTH - 1);
    drop_d = sat_add16(drop_q, {1'b0, drop_inc});
    err_d  = sat_add16(err_q, err_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      s_sof_q  <= 1'b0;
      s_dv_q   <= 1'b0;
      s_data_q <= 8'd0;
      pm_q     <= 4'd0;
      len_hi_q <= 4'd0;
      len_q    <= 12'd0;
      rem_q    <= 12'd0;
      wr_ptr_q <= '0;
      start_q  <= '0;
      acc_q    <= 1'b0;
      pend_q   <= 1'b0;
      free_q   <= FreeW'(BufBytes);
      bp_q     <= 1'b0;
      drop_q   <= 16'd0;
      err_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      s_sof_q  <= s_sof_d;
      s_dv_q   <= s_dv_d;
      s_data_q <= s_data_d;
      pm_q     <= pm_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      start_q  <= start_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      free_q   <= free_d;
      bp_q     <= bp_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  assign bp0        = bp_q;
  assign bp1        = bp_q;
  assign bp2        = bp_q;
  assign bp3        = bp_q;
  assign dbuf_wr    = wr_en;
  assign dbuf_waddr = wr_ptr_q;
  assign dbuf_din   = s_data_q;
  assign drop_cnt   = drop_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_tte_frame_enqueue.sv
// Bench for tte_frame_enqueue: directed and random frames against a frame-level
// model of buffer contents, free space, counters and the descriptor queue.
module tb_tte_frame_enqueue;
  import tte_pkg::*;

  localparam int BufSz = 4096;

  logic        clk = 1'b0;
  logic        rst, sof, dv, desc_ready, rel;
  logic [7:0]  data;
  logic [11:0] rel_len;
  logic        bp0, bp1, bp2, bp3, dbuf_wr, desc_valid;
  logic [11:0] dbuf_waddr;
  logic [7:0]  dbuf_din;
  logic [27:0] desc_data;
  logic [15:0] drop_cnt, err_cnt;

  tte_frame_enqueue #(
    .DBUF_AW    (12),
    .MAX_FRAME  (1536),
    .MIN_FRAME  (60),
    .DESC_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .dv         (dv),
    .data       (data),
    .bp0        (bp0),
    .bp1        (bp1),
    .bp2        (bp2),
    .bp3        (bp3),
    .dbuf_wr    (dbuf_wr),
    .dbuf_waddr (dbuf_waddr),
    .dbuf_din   (dbuf_din),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_data  (desc_data),
    .rel        (rel),
    .rel_len    (rel_len),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Buffer image as seen on the write port.
  logic [7:0] got_mem [BufSz];
  int         wr_cnt = 0;
  always @(negedge clk) begin
    if (dbuf_wr === 1'b1) begin
      got_mem[dbuf_waddr] <= dbuf_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Frame-level reference state.
  int          m_free = BufSz;
  int          m_wp = 0;
  int          m_drop = 0;
  int          m_err = 0;
  logic [27:0] exp_q [$];
  logic [7:0]  body [2048];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit exp_bp();
    return (m_free < 1536) || (exp_q.size() >= 7);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_drop"}, drop_cnt, m_drop);
    chk({tag, "_err"}, err_cnt, m_err);
    chk({tag, "_bp"}, {bp3, bp2, bp1, bp0}, {4{exp_bp()}});
  endtask

  // Sends header + bytes; sent < len truncates, otherwise pad bytes follow.
  // rel_amt > 0 pulses rel in the cycle the frame would commit.
  task automatic run_frame(input logic [3:0] pm, input int len, input int sent, input int pad,
                           input int rel_amt, input string tag);
    int          outcome, w0, nb, start, mism;
    logic [11:0] l12;
    l12   = 12'(len);
    start = m_wp;
    if (pm == 4'd0 || m_free < len || exp_q.size() == 8) outcome = 1;
    else if (len < 60 || len > 1536)                        outcome = 2;
    else if (sent < len)                                    outcome = 3;
    else                                                    outcome = 0;
    nb = (sent < len) ? sent : len + pad;
    for (int i = 0; i < nb; i++) body[i] = 8'($urandom);
    w0 = wr_cnt;
    @(posedge clk); #1 sof = 1'b1; dv = 1'b1; data = {l12[11:8], pm};
    @(posedge clk); #1 sof = 1'b0; data = l12[7:0];
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1 data = body[i];
    end
    @(posedge clk); #1 dv = 1'b0; data = 8'd0;
    if (rel_amt > 0) begin
      @(posedge clk);
      @(posedge clk); #1 rel = 1'b1; rel_len = 12'(rel_amt);
      @(posedge clk); #1 rel = 1'b0; rel_len = 12'd0;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    case (outcome)
      0: begin
        exp_q.push_back({pm, l12, 12'(m_wp)});
        m_free -= len;
        m_wp = (m_wp + len) % BufSz;
        mism = 0;
        for (int i = 0; i < len; i++)
          if (got_mem[(start + i) % BufSz] !== body[i]) mism++;
        chk({tag, "_mem"}, mism, 0);
      end
      1: m_drop++;
      default: m_err++;
    endcase
    if (rel_amt > 0) begin
      m_free += rel_amt;
      if (m_free > BufSz) begin
        m_free = BufSz;
        m_err++;
      end
    end
    chk({tag, "_writes"}, wr_cnt - w0, (outcome == 0) ? len : (outcome == 3) ? sent : 0);
    check_state(tag);
  endtask

  task automatic do_rel(input int n);
    @(posedge clk); #1 rel = 1'b1; rel_len = 12'(n);
    @(posedge clk); #1 rel = 1'b0; rel_len = 12'd0;
    m_free += n;
    if (m_free > BufSz) begin
      m_free = BufSz;
      m_err++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_one(input string tag, input bit release_it);
    logic [27:0] e;
    int          t;
    e = exp_q.pop_front();
    t = 0;
    while (desc_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, desc_valid, 1'b1);
    chk({tag, "_desc"}, desc_data, e);
    desc_ready = 1'b1;
    @(posedge clk); #1 desc_ready = 1'b0;
    @(negedge clk);
    if (release_it) do_rel(int'(e[LEN_HI:LEN_LO]));
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) pop_one("drain", 1'b1);
  endtask

  initial begin
    int          gap, l, len, sent;
    logic [3:0]  pm;
    logic [27:0] held;

    rst = 1'b0; sof = 1'b0; dv = 1'b0; data = 8'd0;
    desc_ready = 1'b0; rel = 1'b0; rel_len = 12'd0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bp", {bp3, bp2, bp1, bp0}, 4'd0);
    chk("rst_wr", dbuf_wr, 1'b0);
    chk("rst_waddr", dbuf_waddr, 12'd0);
    chk("rst_valid", desc_valid, 1'b0);
    chk("rst_desc", desc_data, 28'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_err", err_cnt, 16'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Legal frame with pad, dropped portmap, truncation and restart.
    run_frame(4'h5, 64, 64, 4, 0, "legal");
    pop_one("legal", 1'b1);
    run_frame(4'h0, 100, 100, 2, 0, "pm0");
    run_frame(4'h3, 200, 120, 0, 0, "trunc");
    run_frame(4'h9, 80, 80, 1, 0, "after_trunc");
    pop_one("after_trunc", 1'b1);

    // Fill: two max frames leave 1024 free, the third is dropped.
    run_frame(4'h1, 1536, 1536, 2, 0, "fill1");
    run_frame(4'h2, 1536, 1536, 0, 0, "fill2");
    run_frame(4'h4, 1536, 1536, 0, 0, "fill3");
    do_rel(1536);
    check_state("fill_rel");
    pop_one("fill1", 1'b0);
    pop_one("fill2", 1'b1);

    // Walk the write pointer to 4090, then a frame that wraps.
    while (m_wp != 4090) begin
      gap = (4090 - m_wp + BufSz) % BufSz;
      if (gap > 1596)      l = 1536;
      else if (gap > 1536) l = gap - 60;
      else if (gap >= 60)  l = gap;
      else                 l = 1536;
      run_frame(4'h7, l, l, 0, 0, "walk");
      drain_all();
    end
    run_frame(4'hA, 64, 64, 3, 0, "wrap");
    pop_one("wrap", 1'b1);

    // Commit and release in the same cycle keep free at 1602, so bp stays low.
    run_frame(4'h2, 1536, 1536, 0, 0, "pre1");
    run_frame(4'h2, 994, 994, 0, 0, "pre2");
    run_frame(4'h4, 64, 64, 0, 100, "commit_rel");
    pop_one("cr1", 1'b0);
    pop_one("cr2", 1'b0);
    pop_one("cr3", 1'b0);
    do_rel(1536);
    do_rel(958);
    do_rel(100);
    check_state("clamp");

    // Eight frames with no consumer fill the queue; the ninth is dropped.
    for (int i = 0; i < 8; i++) run_frame(4'(1 + i), 60, 60, 1, 0, "qfill");
    run_frame(4'hF, 60, 60, 0, 0, "qfull");
    held = exp_q[0];
    repeat (5) @(negedge clk);
    chk("hold_valid", desc_valid, 1'b1);
    chk("hold_desc", desc_data, held);
    drain_all();

    // Random frames, including illegal lengths, zero portmaps and truncation.
    for (int k = 0; k < 16; k++) begin
      pm   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      len  = $urandom_range(40, 1600);
      sent = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : len;
      run_frame(pm, len, sent, $urandom_range(0, 5), 0, "rand");
      if ($urandom_range(0, 1) == 1) drain_all();
    end
    drain_all();
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
